ifetch: RTL

IFETCH -- requirements
Module: ifetch

---
 rtl/ifetch_pkg.sv | 10 +
 rtl/ifetch.sv | 82 ++++++++
 2 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared fetch FSM encoding, reset PC default and opcode field position
package ifetch_pkg;
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  function automatic logic [5:0] opcode(input logic [31:0] instr);
    return instr[OPC_HI:OPC_LO];
  endfunction
endpackage

// File: rtl/ifetch.sv
// ifetch: single-outstanding instruction fetch unit with redirect/flush handling
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [5:0]  if_opcode,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        align_err
);
  state_t      state;
  logic [31:0] pc;
  logic        drop;
  logic        hold_valid;
  logic [31:0] target;
  logic        accept;
  assign target    = {redirect_pc[31:2], 2'b00};
  assign accept    = imem_req & imem_ack;
  assign if_valid  = hold_valid & ~redirect;
  assign imem_addr = pc;
  assign if_opcode = opcode(if_instr);
  // drop marks an in-flight response that a redirect has made stale
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      drop       <= 1'b0;
      hold_valid <= 1'b0;
      imem_req   <= 1'b0;
      if_instr   <= '0;
      if_pc      <= '0;
      if_pc4     <= '0;
      align_err  <= 1'b0;
    end else begin
      align_err <= redirect & |redirect_pc[1:0];
      if (redirect) pc <= target;
      case (state)
        S_REQ:
          if (accept) begin
            state    <= S_WAIT;
            imem_req <= 1'b0;
            drop     <= redirect;
          end else imem_req <= 1'b1;
        S_WAIT:
          if (imem_rvalid) begin
            drop <= 1'b0;
            if (redirect | drop) begin
              state    <= S_REQ;
              imem_req <= 1'b1;
            end else begin
              state      <= S_HOLD;
              hold_valid <= 1'b1;
              if_instr   <= imem_rdata;
              if_pc      <= pc;
              if_pc4     <= pc + 32'd4;
            end
          end else if (redirect) drop <= 1'b1;
        S_HOLD:
          if (redirect | if_ready) begin
            state      <= S_REQ;
            imem_req   <= 1'b1;
            hold_valid <= 1'b0;
            if (!redirect) pc <= pc + 32'd4;
          end
        default: state <= S_REQ;
      endcase
    end
  end
endmodule
